// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster scan bundle from the timing generator to the pixel colour stage
//   master: drives the scan (timing generator side)
//   slave : consumes the scan (colour/sprite stage, sync pins)
//   hpos/vpos    : current column/line counters
//   hsync/vsync  : sync pins, pipelined to line up with registered RGB
//   visible      : active-video flag, pipelined like the syncs
//   line_start   : one-clk pulse when hpos has just wrapped to 0
//   frame_start  : one-clk pulse when (hpos,vpos) has just wrapped to (0,0)
//   frame_count  : completed frames, wraps at 1024
interface vga_timing_gen_if;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       hsync;
    logic       vsync;
    logic       visible;
    logic       line_start;
    logic       frame_start;
    logic [9:0] frame_count;

    modport master (
        output hpos, vpos, hsync, vsync, visible, line_start, frame_start, frame_count
    );

    modport slave (
        input hpos, vpos, hsync, vsync, visible, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters, sync/visible decode with alignment pipeline, frame bookkeeping
//   clk    : pixel-domain clock
//   rst_n  : synchronous active-low reset
//   en_i   : pixel advance enable; counters step only when high
//   vga_o  : scan outputs (see vga_timing_gen_if)
module vga_timing_gen #(
    parameter int H_DISPLAY   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_DISPLAY   = 480,
    parameter int V_BOTTOM    = 10,
    parameter int V_SYNC      = 2,
    parameter int V_TOP       = 33,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int PIPE_DELAY  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    vga_timing_gen_if.master vga_o
);
    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    // Decode bounds are 11 bits so a region ending exactly at 1024 still compares correctly.
    localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
    localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
    localparam logic [10:0] HS_START = 11'(H_DISPLAY + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_DISPLAY + V_BOTTOM);
    localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_BOTTOM + V_SYNC);
    // Pipeline word is {hsync, vsync, visible}; idle means syncs inactive and blanked.
    localparam logic [2:0] PIPE_IDLE = {~SYNC_ACTIVE, ~SYNC_ACTIVE, 1'b0};

    logic [9:0]  hpos_q, hpos_d;
    logic [9:0]  vpos_q, vpos_d;
    logic [9:0]  frame_count_q, frame_count_d;
    logic        line_start_q, line_start_d;
    logic        frame_start_q, frame_start_d;
    logic        at_h_end, at_v_end;
    logic [10:0] h_ext, v_ext;
    logic        hs_raw, vs_raw, vis_raw;
    logic [2:0]  pipe_q [PIPE_DELAY];

    assign at_h_end = hpos_q == H_LAST;
    assign at_v_end = vpos_q == V_LAST;

    assign hpos_d        = !en_i ? hpos_q : at_h_end ? 10'd0 : hpos_q + 10'd1;
    assign vpos_d        = !(en_i && at_h_end) ? vpos_q : at_v_end ? 10'd0 : vpos_q + 10'd1;
    assign line_start_d  = en_i && at_h_end;
    assign frame_start_d = en_i && at_h_end && at_v_end;
    assign frame_count_d = frame_start_d ? frame_count_q + 10'd1 : frame_count_q;

    assign h_ext   = {1'b0, hpos_q};
    assign v_ext   = {1'b0, vpos_q};
    assign hs_raw  = (h_ext >= HS_START && h_ext < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vs_raw  = (v_ext >= VS_START && v_ext < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign vis_raw = (h_ext < H_VIS) && (v_ext < V_VIS);

    // The decode pipeline shifts every clock, independent of en_i, so a held
    // position settles onto the outputs after PIPE_DELAY clocks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hpos_q        <= '0;
            vpos_q        <= '0;
            frame_count_q <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            for (int i = 0; i < PIPE_DELAY; i++) pipe_q[i] <= PIPE_IDLE;
        end else begin
            hpos_q        <= hpos_d;
            vpos_q        <= vpos_d;
            frame_count_q <= frame_count_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            pipe_q[0]     <= {hs_raw, vs_raw, vis_raw};
            for (int i = 1; i < PIPE_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign vga_o.hpos        = hpos_q;
    assign vga_o.vpos        = vpos_q;
    assign vga_o.hsync       = pipe_q[PIPE_DELAY-1][2];
    assign vga_o.vsync       = pipe_q[PIPE_DELAY-1][1];
    assign vga_o.visible     = pipe_q[PIPE_DELAY-1][0];
    assign vga_o.line_start  = line_start_q;
    assign vga_o.frame_start = frame_start_q;
    assign vga_o.frame_count = frame_count_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the VGA timing generator in three configurations
//   u_a: default 640x480 timing, PIPE_DELAY=1, active-low syncs
//   u_b: default timing, PIPE_DELAY=3, active-high syncs
//   u_c: 8x4 total timing for full-frame and frame-counter wrap checks
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    int checks = 0;
    int fails = 0;

    vga_timing_gen_if va();
    vga_timing_gen_if vb();
    vga_timing_gen_if vc();

    vga_timing_gen u_a (.clk(clk), .rst_n(rst_n), .en_i(en), .vga_o(va));

    vga_timing_gen #(.SYNC_ACTIVE(1'b1), .PIPE_DELAY(3)) u_b (
        .clk(clk), .rst_n(rst_n), .en_i(en), .vga_o(vb)
    );

    // 4 visible + 1 front + 2 sync + 1 back = 8 clks/line; 2 visible + 1 bottom + 1 sync = 4 lines.
    vga_timing_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(2), .V_BOTTOM(1), .V_SYNC(1), .V_TOP(0)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .en_i(en), .vga_o(vc)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (va.hpos !== 10'd0) begin fails++; $display("FAIL reset_hpos: got %0d expected 0", va.hpos); end
        checks++; if (va.vpos !== 10'd0) begin fails++; $display("FAIL reset_vpos: got %0d expected 0", va.vpos); end
        checks++; if (va.hsync !== 1'b1) begin fails++; $display("FAIL reset_hsync: got %0b expected 1", va.hsync); end
        checks++; if (va.vsync !== 1'b1) begin fails++; $display("FAIL reset_vsync: got %0b expected 1", va.vsync); end
        checks++; if (va.visible !== 1'b0) begin fails++; $display("FAIL reset_visible: got %0b expected 0", va.visible); end
        checks++; if (va.line_start !== 1'b0) begin fails++; $display("FAIL reset_line_start: got %0b expected 0", va.line_start); end
        checks++; if (va.frame_start !== 1'b0) begin fails++; $display("FAIL reset_frame_start: got %0b expected 0", va.frame_start); end
        checks++; if (va.frame_count !== 10'd0) begin fails++; $display("FAIL reset_frame_count: got %0d expected 0", va.frame_count); end
        checks++; if (vb.hsync !== 1'b0) begin fails++; $display("FAIL reset_hsync_hi_active: got %0b expected 0", vb.hsync); end
        checks++; if (vb.vsync !== 1'b0) begin fails++; $display("FAIL reset_vsync_hi_active: got %0b expected 0", vb.vsync); end
        checks++; if (vb.visible !== 1'b0) begin fails++; $display("FAIL reset_visible_pipe3: got %0b expected 0", vb.visible); end
        en = 1'b1;
        @(negedge clk);
        checks++; if (va.hpos !== 10'd1) begin fails++; $display("FAIL reset_exit_hpos: got %0d expected 1", va.hpos); end
        checks++; if (va.line_start !== 1'b0) begin fails++; $display("FAIL reset_exit_line_start: got %0b expected 0", va.line_start); end
        checks++; if (va.frame_start !== 1'b0) begin fails++; $display("FAIL reset_exit_frame_start: got %0b expected 0", va.frame_start); end
    endtask

    task automatic test_first_line();
        int p;
        int hs_low = 0;
        int ls_cnt = 0;
        logic exp_hs, exp_vis, exp_ls;
        do_reset();
        en = 1'b1;
        for (int c = 1; c <= 800; c++) begin
            @(negedge clk);
            p = c - 1;
            exp_hs = !(p >= 656 && p < 752);
            exp_vis = p < 640;
            exp_ls = c == 800;
            checks++; if (va.hpos !== 10'(c % 800)) begin fails++; $display("FAIL line_hpos c=%0d: got %0d expected %0d", c, va.hpos, c % 800); end
            checks++; if (va.vpos !== 10'(c / 800)) begin fails++; $display("FAIL line_vpos c=%0d: got %0d expected %0d", c, va.vpos, c / 800); end
            checks++; if (va.hsync !== exp_hs) begin fails++; $display("FAIL line_hsync c=%0d: got %0b expected %0b", c, va.hsync, exp_hs); end
            checks++; if (va.visible !== exp_vis) begin fails++; $display("FAIL line_visible c=%0d: got %0b expected %0b", c, va.visible, exp_vis); end
            checks++; if (va.line_start !== exp_ls) begin fails++; $display("FAIL line_start c=%0d: got %0b expected %0b", c, va.line_start, exp_ls); end
            checks++; if (va.vsync !== 1'b1) begin fails++; $display("FAIL line_vsync c=%0d: got %0b expected 1", c, va.vsync); end
            if (!va.hsync) hs_low++;
            if (va.line_start) ls_cnt++;
        end
        checks++; if (hs_low !== 96) begin fails++; $display("FAIL line_hsync_width: got %0d expected 96", hs_low); end
        checks++; if (ls_cnt !== 1) begin fails++; $display("FAIL line_start_count: got %0d expected 1", ls_cnt); end
    endtask

    task automatic test_pipe_delay();
        int p;
        int hs_rise = -1;
        int vis_fall = -1;
        logic exp_hs, exp_vis;
        do_reset();
        en = 1'b1;
        for (int c = 1; c <= 800; c++) begin
            @(negedge clk);
            p = c - 3;
            exp_hs = p >= 656 && p < 752;
            exp_vis = p >= 0 && p < 640;
            checks++; if (vb.hsync !== exp_hs) begin fails++; $display("FAIL pipe3_hsync c=%0d: got %0b expected %0b", c, vb.hsync, exp_hs); end
            checks++; if (vb.visible !== exp_vis) begin fails++; $display("FAIL pipe3_visible c=%0d: got %0b expected %0b", c, vb.visible, exp_vis); end
            checks++; if (vb.vsync !== 1'b0) begin fails++; $display("FAIL pipe3_vsync c=%0d: got %0b expected 0", c, vb.vsync); end
            if (vb.hsync && hs_rise < 0) hs_rise = c;
            if (!vb.visible && c > 3 && vis_fall < 0) vis_fall = c;
        end
        checks++; if (hs_rise !== 659) begin fails++; $display("FAIL pipe3_hsync_rise: got cycle %0d expected 659", hs_rise); end
        checks++; if (vis_fall !== 643) begin fails++; $display("FAIL pipe3_visible_fall: got cycle %0d expected 643", vis_fall); end
    endtask

    task automatic test_half_rate();
        int ls_cnt = 0;
        logic exp_ls;
        do_reset();
        for (int k = 0; k < 1600; k++) begin
            en = (k % 2) == 0;
            @(negedge clk);
            exp_ls = k == 1598;
            checks++; if (va.hpos !== 10'((k / 2 + 1) % 800)) begin fails++; $display("FAIL half_hpos k=%0d: got %0d expected %0d", k, va.hpos, (k / 2 + 1) % 800); end
            checks++; if (va.vpos !== 10'(k >= 1598)) begin fails++; $display("FAIL half_vpos k=%0d: got %0d expected %0d", k, va.vpos, k >= 1598); end
            checks++; if (va.line_start !== exp_ls) begin fails++; $display("FAIL half_line_start k=%0d: got %0b expected %0b", k, va.line_start, exp_ls); end
            if (va.line_start) ls_cnt++;
        end
        checks++; if (ls_cnt !== 1) begin fails++; $display("FAIL half_line_start_count: got %0d expected 1", ls_cnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1;
        repeat (700) @(negedge clk);
        checks++; if (va.hpos !== 10'd700) begin fails++; $display("FAIL mid_pre_hpos: got %0d expected 700", va.hpos); end
        checks++; if (va.hsync !== 1'b0) begin fails++; $display("FAIL mid_pre_hsync: got %0b expected 0", va.hsync); end
        checks++; if (vc.vsync !== 1'b0) begin fails++; $display("FAIL mid_pre_vsync_small: got %0b expected 0", vc.vsync); end
        checks++; if (vc.frame_count !== 10'd21) begin fails++; $display("FAIL mid_pre_frame_count_small: got %0d expected 21", vc.frame_count); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (va.hpos !== 10'd0) begin fails++; $display("FAIL mid_hpos: got %0d expected 0", va.hpos); end
        checks++; if (va.vpos !== 10'd0) begin fails++; $display("FAIL mid_vpos: got %0d expected 0", va.vpos); end
        checks++; if (va.hsync !== 1'b1) begin fails++; $display("FAIL mid_hsync: got %0b expected 1", va.hsync); end
        checks++; if (va.vsync !== 1'b1) begin fails++; $display("FAIL mid_vsync: got %0b expected 1", va.vsync); end
        checks++; if (va.visible !== 1'b0) begin fails++; $display("FAIL mid_visible: got %0b expected 0", va.visible); end
        checks++; if (vc.hpos !== 10'd0) begin fails++; $display("FAIL mid_hpos_small: got %0d expected 0", vc.hpos); end
        checks++; if (vc.vpos !== 10'd0) begin fails++; $display("FAIL mid_vpos_small: got %0d expected 0", vc.vpos); end
        checks++; if (vc.vsync !== 1'b1) begin fails++; $display("FAIL mid_vsync_small: got %0b expected 1", vc.vsync); end
        checks++; if (vc.frame_count !== 10'd0) begin fails++; $display("FAIL mid_frame_count_small: got %0d expected 0", vc.frame_count); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (va.hpos !== 10'd1) begin fails++; $display("FAIL mid_exit_hpos: got %0d expected 1", va.hpos); end
        checks++; if (va.line_start !== 1'b0) begin fails++; $display("FAIL mid_exit_line_start: got %0b expected 0", va.line_start); end
        checks++; if (vc.frame_start !== 1'b0) begin fails++; $display("FAIL mid_exit_frame_start_small: got %0b expected 0", vc.frame_start); end
        checks++; if (vc.line_start !== 1'b0) begin fails++; $display("FAIL mid_exit_line_start_small: got %0b expected 0", vc.line_start); end
    endtask

    task automatic test_full_frame();
        int vs_low = 0;
        int hs_low = 0;
        int vis_hi = 0;
        int fs_cnt = 0;
        int fs_at = -1;
        int ls_cnt = 0;
        do_reset();
        en = 1'b1;
        for (int c = 1; c <= 32; c++) begin
            @(negedge clk);
            if (!vc.vsync) vs_low++;
            if (!vc.hsync) hs_low++;
            if (vc.visible) vis_hi++;
            if (vc.line_start) ls_cnt++;
            if (vc.frame_start) begin fs_cnt++; fs_at = c; end
        end
        checks++; if (vs_low !== 8) begin fails++; $display("FAIL frame_vsync_width: got %0d expected 8", vs_low); end
        checks++; if (hs_low !== 8) begin fails++; $display("FAIL frame_hsync_total: got %0d expected 8", hs_low); end
        checks++; if (vis_hi !== 8) begin fails++; $display("FAIL frame_visible_total: got %0d expected 8", vis_hi); end
        checks++; if (ls_cnt !== 4) begin fails++; $display("FAIL frame_line_starts: got %0d expected 4", ls_cnt); end
        checks++; if (fs_cnt !== 1) begin fails++; $display("FAIL frame_start_count: got %0d expected 1", fs_cnt); end
        checks++; if (fs_at !== 32) begin fails++; $display("FAIL frame_start_cycle: got %0d expected 32", fs_at); end
        checks++; if (vc.line_start !== 1'b1) begin fails++; $display("FAIL frame_line_start_coincident: got %0b expected 1", vc.line_start); end
        checks++; if (vc.frame_count !== 10'd1) begin fails++; $display("FAIL frame_count_one: got %0d expected 1", vc.frame_count); end
    endtask

    task automatic test_frame_wrap();
        int bad = 0;
        int fs_cnt = 0;
        do_reset();
        en = 1'b1;
        for (int c = 1; c <= 32768; c++) begin
            @(negedge clk);
            if (vc.frame_count !== 10'((c / 32) % 1024)) bad++;
            if (vc.frame_start) fs_cnt++;
            if (c == 32736) begin
                checks++; if (vc.frame_count !== 10'd1023) begin fails++; $display("FAIL wrap_pre_count: got %0d expected 1023", vc.frame_count); end
            end
        end
        checks++; if (bad !== 0) begin fails++; $display("FAIL wrap_count_track: got %0d bad cycles expected 0", bad); end
        checks++; if (fs_cnt !== 1024) begin fails++; $display("FAIL wrap_frame_starts: got %0d expected 1024", fs_cnt); end
        checks++; if (vc.frame_count !== 10'd0) begin fails++; $display("FAIL wrap_count_zero: got %0d expected 0", vc.frame_count); end
        checks++; if (vc.frame_start !== 1'b1) begin fails++; $display("FAIL wrap_frame_start: got %0b expected 1", vc.frame_start); end
    endtask

    initial begin
        test_reset();
        test_first_line();
        test_pipe_delay();
        test_half_rate();
        test_reset_mid();
        test_full_frame();
        test_frame_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
